// File: rtl/cpu_regfile_pkg.sv
// rtl/cpu_regfile_pkg.sv - shared enums and status bit positions for cpu_regfile_gen
package cpu_regfile_pkg;

  typedef enum logic [2:0] {
    PTR_NONE = 3'd0,
    PTR_LDL  = 3'd1,
    PTR_LDH  = 3'd2,
    PTR_ALUL = 3'd3,
    PTR_ALUH = 3'd4,
    PTR_INC  = 3'd5,
    PTR_DEC  = 3'd6,
    PTR_CLRH = 3'd7
  } ptr_op_e;

  typedef enum logic [1:0] {
    SP_IDLE = 2'd0,
    SP_HI   = 2'd1,
    SP_LO   = 2'd2,
    SP_ST   = 2'd3
  } spill_state_e;

  localparam int ST_N = 7;
  localparam int ST_V = 6;
  localparam int ST_R = 5;
  localparam int ST_B = 4;
  localparam int ST_D = 3;
  localparam int ST_I = 2;
  localparam int ST_Z = 1;
  localparam int ST_C = 0;

endpackage

// File: rtl/cpu_regfile_gen_if.sv
// rtl/cpu_regfile_gen_if.sv - data bus and spill handshake bundle
interface cpu_regfile_gen_if #(
  parameter int DW  = 8,
  parameter int PIW = 2
);
  logic [DW-1:0]  data_in;
  logic           bus_ready;
  logic           spill_req;
  logic [PIW-1:0] spill_ptr;
  logic           spill_stat;
  logic           spill_brk;
  logic [DW-1:0]  data_out;
  logic           data_oe;
  logic           spill_busy;
  logic           spill_done;

  modport master (
    output data_in, bus_ready, spill_req, spill_ptr, spill_stat, spill_brk,
    input  data_out, data_oe, spill_busy, spill_done
  );

  modport slave (
    input  data_in, bus_ready, spill_req, spill_ptr, spill_stat, spill_brk,
    output data_out, data_oe, spill_busy, spill_done
  );
endinterface

// File: rtl/cpu_regfile_gen_spill_seq.sv
// rtl/cpu_regfile_gen_spill_seq.sv - spill FSM with snapshot registers and registered bus drive
module spill_seq
  import cpu_regfile_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          spill_req,
  input  logic [2*DW-1:0] spill_ptr_val,
  input  logic          spill_stat,
  input  logic          spill_brk,
  input  logic [DW-1:0] status,
  input  logic          bus_ready,
  input  logic          st_en,
  input  logic [DW-1:0] st_data,
  output logic [DW-1:0] data_out,
  output logic          data_oe,
  output logic          spill_busy,
  output logic          spill_done
);

  spill_state_e    state_q, state_d;
  logic [2*DW-1:0] snap_ptr_q, snap_ptr_d;
  logic [DW-1:0]   snap_stat_q, snap_stat_d;
  logic            snap_has_q, snap_has_d;
  logic [DW-1:0]   out_q, out_d;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            last_acc;

  always_comb begin
    state_d     = state_q;
    snap_ptr_d  = snap_ptr_q;
    snap_stat_d = snap_stat_q;
    snap_has_d  = snap_has_q;
    out_d       = out_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    last_acc    = 1'b0;
    if (!stall) begin
      case (state_q)
        SP_IDLE: begin
          oe_d  = st_en;
          out_d = st_en ? st_data : '0;
          if (spill_req) begin
            snap_ptr_d        = spill_ptr_val;
            snap_has_d        = spill_stat;
            snap_stat_d       = status;
            snap_stat_d[ST_B] = spill_brk;
            snap_stat_d[ST_R] = 1'b1;
            state_d           = SP_HI;
            busy_d            = 1'b1;
            oe_d              = 1'b1;
            out_d             = spill_ptr_val[2*DW-1:DW];
          end
        end
        SP_HI: if (bus_ready) begin
          state_d = SP_LO;
          out_d   = snap_ptr_q[DW-1:0];
        end
        SP_LO: if (bus_ready) begin
          if (snap_has_q) begin
            state_d = SP_ST;
            out_d   = snap_stat_q;
          end else begin
            last_acc = 1'b1;
          end
        end
        SP_ST: if (bus_ready) last_acc = 1'b1;
        default: state_d = SP_IDLE;
      endcase
      // Final beat accepted: release the bus back to the st_en path
      if (last_acc) begin
        state_d = SP_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        oe_d    = st_en;
        out_d   = st_en ? st_data : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SP_IDLE;
      snap_ptr_q  <= '0;
      snap_stat_q <= '0;
      snap_has_q  <= 1'b0;
      out_q       <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_ptr_q  <= snap_ptr_d;
      snap_stat_q <= snap_stat_d;
      snap_has_q  <= snap_has_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign data_out   = out_q;
  assign data_oe    = oe_q;
  assign spill_busy = busy_q;
  assign spill_done = done_q;

endmodule

// File: rtl/cpu_regfile_gen.sv
// rtl/cpu_regfile_gen.sv - general/pointer/status register file with spill sequencer
// CPU_REGFILE_SHADOW_EN adds bank_swap and a second general-register bank.
module cpu_regfile_gen
  import cpu_regfile_pkg::*;
#(
  parameter int          DW          = 8,
  parameter int          NREG        = 8,
  parameter int          NPTR        = 4,
  parameter logic [DW-1:0] STATUS_RST  = 8'h20,
  parameter logic [DW-1:0] STATUS_KEEP = 8'h30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [DW-1:0]            alu_out,
  input  logic                     ld_en,
  input  logic [$clog2(NREG)-1:0]  ld_idx,
  input  logic                     dest_en,
  input  logic [$clog2(NREG)-1:0]  dest_idx,
  input  logic [$clog2(NREG)-1:0]  rd_a_idx,
  input  logic [$clog2(NREG)-1:0]  rd_b_idx,
  output logic [DW-1:0]            rd_a,
  output logic [DW-1:0]            rd_b,
  input  logic [$clog2(NPTR)-1:0]  ptr_idx,
  input  logic [2:0]               ptr_op,
  output logic [NPTR*2*DW-1:0]     ptr_q,
  input  logic [DW-1:0]            status_we,
  input  logic [DW-1:0]            status_d,
  input  logic                     status_ld,
  output logic [DW-1:0]            status_q,
  input  logic                     st_en,
  input  logic [$clog2(NREG)-1:0]  st_idx,
`ifdef CPU_REGFILE_SHADOW_EN
  input  logic                     bank_swap,
`endif
  cpu_regfile_gen_if.slave         bus
);

  localparam int IW = $clog2(NREG);
  localparam int PW = 2 * DW;

`ifdef CPU_REGFILE_SHADOW_EN
  localparam int NB = 2;
  logic          bank_q, bank_d;
  logic [IW:0]   ld_a, dest_a, rda_a, rdb_a, st_a;

  assign ld_a   = {bank_q, ld_idx};
  assign dest_a = {bank_q, dest_idx};
  assign rda_a  = {bank_q, rd_a_idx};
  assign rdb_a  = {bank_q, rd_b_idx};
  assign st_a   = {bank_q, st_idx};

  always_comb bank_d = (bank_swap && !stall) ? ~bank_q : bank_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bank_q <= 1'b0;
    else      bank_q <= bank_d;
  end
`else
  localparam int NB = 1;
  logic [IW-1:0] ld_a, dest_a, rda_a, rdb_a, st_a;

  assign ld_a   = ld_idx;
  assign dest_a = dest_idx;
  assign rda_a  = rd_a_idx;
  assign rdb_a  = rd_b_idx;
  assign st_a   = st_idx;
`endif

  logic [DW-1:0] regs_q [NB*NREG];
  logic [DW-1:0] regs_d [NB*NREG];
  logic [PW-1:0] preg_q [NPTR];
  logic [PW-1:0] preg_d [NPTR];
  logic [DW-1:0] stat_reg_q, stat_reg_d;

  // dest first so a same-index ld overrides it
  always_comb begin
    regs_d = regs_q;
    if (!stall) begin
      if (dest_en) regs_d[dest_a] = alu_out;
      if (ld_en)   regs_d[ld_a]   = bus.data_in;
    end
  end

  always_comb begin
    preg_d = preg_q;
    if (!stall) begin
      case (ptr_op_e'(ptr_op))
        PTR_LDL:  preg_d[ptr_idx][DW-1:0]  = bus.data_in;
        PTR_LDH:  preg_d[ptr_idx][PW-1:DW] = bus.data_in;
        PTR_ALUL: preg_d[ptr_idx][DW-1:0]  = alu_out;
        PTR_ALUH: preg_d[ptr_idx][PW-1:DW] = alu_out;
        PTR_INC:  preg_d[ptr_idx]          = preg_q[ptr_idx] + PW'(1);
        PTR_DEC:  preg_d[ptr_idx]          = preg_q[ptr_idx] - PW'(1);
        PTR_CLRH: preg_d[ptr_idx][PW-1:DW] = '0;
        default:  ;
      endcase
    end
  end

  // PLP-style load keeps the protected bits and wins over per-bit writes
  always_comb begin
    stat_reg_d = stat_reg_q;
    if (!stall) begin
      if (status_ld)
        stat_reg_d = (bus.data_in & ~STATUS_KEEP) | (stat_reg_q & STATUS_KEEP);
      else
        stat_reg_d = (status_d & status_we) | (stat_reg_q & ~status_we);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NB*NREG; i++) regs_q[i] <= '0;
      for (int k = 0; k < NPTR; k++)    preg_q[k] <= '0;
      stat_reg_q <= STATUS_RST;
    end else begin
      regs_q     <= regs_d;
      preg_q     <= preg_d;
      stat_reg_q <= stat_reg_d;
    end
  end

  assign rd_a     = regs_q[rda_a];
  assign rd_b     = regs_q[rdb_a];
  assign status_q = stat_reg_q;

  for (genvar k = 0; k < NPTR; k++) begin : g_ptr_flat
    assign ptr_q[k*PW +: PW] = preg_q[k];
  end

  spill_seq #(.DW(DW)) u_spill_seq (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .spill_req     (bus.spill_req),
    .spill_ptr_val (preg_q[bus.spill_ptr]),
    .spill_stat    (bus.spill_stat),
    .spill_brk     (bus.spill_brk),
    .status        (stat_reg_q),
    .bus_ready     (bus.bus_ready),
    .st_en         (st_en),
    .st_data       (regs_q[st_a]),
    .data_out      (bus.data_out),
    .data_oe       (bus.data_oe),
    .spill_busy    (bus.spill_busy),
    .spill_done    (bus.spill_done)
  );

endmodule

// File: tb/tb_cpu_regfile_gen.sv
// tb/tb_cpu_regfile_gen.sv - directed scoreboard bench for cpu_regfile_gen
module tb_cpu_regfile_gen;
  import cpu_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [7:0]  alu_out;
  logic        ld_en, dest_en, st_en, status_ld;
  logic [2:0]  ld_idx, dest_idx, rd_a_idx, rd_b_idx, st_idx;
  logic [7:0]  rd_a, rd_b;
  logic [1:0]  ptr_idx;
  logic [2:0]  ptr_op;
  logic [63:0] ptr_q;
  logic [7:0]  status_we, status_d, status_q;
`ifdef CPU_REGFILE_SHADOW_EN
  logic        bank_swap;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  cpu_regfile_gen_if #(.DW(8), .PIW(2)) bus ();

  cpu_regfile_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .alu_out(alu_out),
    .ld_en(ld_en), .ld_idx(ld_idx), .dest_en(dest_en), .dest_idx(dest_idx),
    .rd_a_idx(rd_a_idx), .rd_b_idx(rd_b_idx), .rd_a(rd_a), .rd_b(rd_b),
    .ptr_idx(ptr_idx), .ptr_op(ptr_op), .ptr_q(ptr_q),
    .status_we(status_we), .status_d(status_d), .status_ld(status_ld),
    .status_q(status_q), .st_en(st_en), .st_idx(st_idx),
`ifdef CPU_REGFILE_SHADOW_EN
    .bank_swap(bank_swap),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!bus.spill_done && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.spill_done) begin
      errors++;
      $display("FAIL spill_timeout act=0 exp=1");
    end
  endtask

  // Monitor: every accepted beat pops the next expected byte
  always @(negedge clk) begin
    if (rst && !stall && bus.spill_busy && bus.bus_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected act=%h exp=none", bus.data_out);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (bus.data_out !== e || bus.data_oe !== 1'b1) begin
          errors++;
          $display("FAIL beat act=%h oe=%b exp=%h oe=1", bus.data_out, bus.data_oe, e);
        end
      end
    end
    if (rst && bus.spill_done) begin
      done_cnt++;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL done_early act=%0d exp=0 pending", exp_q.size());
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; alu_out = '0;
    ld_en = 0; dest_en = 0; st_en = 0; status_ld = 0;
    ld_idx = 0; dest_idx = 0; rd_a_idx = 0; rd_b_idx = 0; st_idx = 0;
    ptr_idx = 0; ptr_op = PTR_NONE; status_we = 0; status_d = 0;
`ifdef CPU_REGFILE_SHADOW_EN
    bank_swap = 0;
`endif
    bus.data_in = 0; bus.bus_ready = 0; bus.spill_req = 0; bus.spill_ptr = 0;
    bus.spill_stat = 0; bus.spill_brk = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", {56'h0, status_q}, 64'h20);
    chk("rst_ptr", ptr_q, 64'h0);
    chk("rst_oe", {63'h0, bus.data_oe}, 64'h0);
    rst = 1'b1;
    tick();

    // reset in the middle of activity
    ptr_idx = 0; ptr_op = PTR_LDL; bus.data_in = 8'h34; status_we = 8'hFF; status_d = 8'h00;
    tick();
    ptr_op = PTR_NONE; status_we = 0;
    chk("pre_rst_ptr0", ptr_q, 64'h34);
    rst = 1'b0;
    #1;
    chk("midrst_status", {56'h0, status_q}, 64'h20);
    chk("midrst_ptr", ptr_q, 64'h0);
    rst = 1'b1;
    tick();

    ld_en = 1; ld_idx = 3; bus.data_in = 8'hA5; rd_a_idx = 3;
    #1;
    chk("rd_pre_edge", {56'h0, rd_a}, 64'h0);
    tick();
    ld_en = 0;
    chk("ld_a5", {56'h0, rd_a}, 64'hA5);

    // write priority
    ld_en = 1; ld_idx = 2; dest_en = 1; dest_idx = 2; bus.data_in = 8'h11; alu_out = 8'h22;
    tick();
    ld_en = 0; dest_en = 0; rd_a_idx = 2;
    chk("prio_same", {56'h0, rd_a}, 64'h11);
    dest_en = 1; dest_idx = 2; alu_out = 8'h00;
    tick();
    ld_en = 1; ld_idx = 2; dest_en = 1; dest_idx = 4; bus.data_in = 8'h11; alu_out = 8'h22;
    tick();
    ld_en = 0; dest_en = 0; rd_b_idx = 4;
    chk("prio_diff_r2", {56'h0, rd_a}, 64'h11);
    chk("prio_diff_r4", {56'h0, rd_b}, 64'h22);

    // pointer ops and wrap on ptr2
    ptr_idx = 2; ptr_op = PTR_LDL; bus.data_in = 8'hFF; tick();
    ptr_op = PTR_LDH; tick();
    chk("ptr_ffff", {48'h0, ptr_q[47:32]}, 64'hFFFF);
    ptr_op = PTR_INC; tick();
    chk("ptr_inc_wrap", {48'h0, ptr_q[47:32]}, 64'h0000);
    ptr_op = PTR_DEC; tick();
    chk("ptr_dec_wrap", {48'h0, ptr_q[47:32]}, 64'hFFFF);
    ptr_op = PTR_CLRH; tick();
    chk("ptr_clrh", {48'h0, ptr_q[47:32]}, 64'h00FF);
    ptr_idx = 1; ptr_op = PTR_ALUH; alu_out = 8'hC0; tick();
    ptr_op = PTR_ALUL; alu_out = 8'h12; tick();
    ptr_op = PTR_NONE;
    chk("ptr1_alu", ptr_q, 64'h0000_00FF_C012_0000);

    // status
    status_ld = 1; bus.data_in = 8'hFF; tick();
    chk("status_ld", {56'h0, status_q}, 64'hEF);
    bus.data_in = 8'h00; status_we = 8'hFF; status_d = 8'hAA; tick();
    status_ld = 0;
    chk("status_ld_prio", {56'h0, status_q}, 64'h20);
    status_we = 8'h81; status_d = 8'hFF; tick();
    chk("status_we_bits", {56'h0, status_q}, 64'hA1);
    status_we = 8'hFF; status_d = 8'hC3; tick();
    status_we = 0;
    chk("status_c3", {56'h0, status_q}, 64'hC3);

    // spill with status, ready held low, ptr/status modified mid-spill
    bus.spill_req = 1; bus.spill_ptr = 1; bus.spill_stat = 1; bus.spill_brk = 0; bus.bus_ready = 0;
    exp_q.push_back(8'hC0); exp_q.push_back(8'h12); exp_q.push_back(8'hE3);
    tick();
    chk("spill_busy", {62'h0, bus.spill_busy, bus.data_oe}, 64'h3);
    bus.spill_req = 0; ptr_idx = 1; ptr_op = PTR_INC; status_we = 8'hFF; status_d = 8'h00;
    tick();
    ptr_op = PTR_NONE; status_we = 0; bus.spill_req = 1;
    tick();
    bus.spill_req = 0; bus.bus_ready = 1;
    wait_done(10);
    bus.bus_ready = 0;
    chk("spill_oe_off", {62'h0, bus.spill_busy, bus.data_oe}, 64'h0);
    chk("ptr1_inc", {48'h0, ptr_q[31:16]}, 64'hC013);
    tick();
    chk("done_pulse", {63'h0, bus.spill_done}, 64'h0);

    // stall freezes the HI beat and pointer updates
    bus.spill_req = 1; bus.spill_ptr = 1; bus.spill_stat = 1; bus.spill_brk = 1;
    exp_q.push_back(8'hC0); exp_q.push_back(8'h13); exp_q.push_back(8'h30);
    tick();
    bus.spill_req = 0; stall = 1; bus.bus_ready = 1; ptr_op = PTR_INC;
    tick(); tick();
    chk("stall_hold", {46'h0, bus.spill_busy, bus.data_oe, bus.data_out, ptr_q[31:16]}, {46'h0, 2'b11, 8'hC0, 16'hC013});
    stall = 0; ptr_op = PTR_NONE;
    wait_done(10);
    bus.bus_ready = 0;

    // st_en drive path
    st_en = 1; st_idx = 4; tick();
    chk("st_drive", {55'h0, bus.data_oe, bus.data_out}, {55'h0, 1'b1, 8'h22});
    st_en = 0; tick();
    chk("st_release", {55'h0, bus.data_oe, bus.data_out}, 64'h0);

    // two-beat spill at minimum latency
    bus.spill_req = 1; bus.spill_ptr = 2; bus.spill_stat = 0; bus.bus_ready = 1;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    tick();
    bus.spill_req = 0;
    tick();
    chk("lat_not_yet", {63'h0, bus.spill_done}, 64'h0);
    tick();
    chk("lat_done", {63'h0, bus.spill_done}, 64'h1);
    tick();
    chk("lat_pulse_end", {62'h0, bus.spill_done, bus.spill_busy}, 64'h0);
    bus.bus_ready = 0;

    // reset while a spill is in flight
    bus.spill_req = 1; bus.spill_ptr = 2;
    tick();
    bus.spill_req = 0;
    rst = 1'b0;
    #1;
    chk("rst_spill", {61'h0, bus.data_oe, bus.spill_busy, bus.spill_done}, 64'h0);
    chk("rst_spill_st", {56'h0, status_q}, 64'h20);
    rst = 1'b1;
    tick();
    chk("rst_no_done", {62'h0, bus.spill_done, bus.spill_busy}, 64'h0);

`ifdef CPU_REGFILE_SHADOW_EN
    rd_a_idx = 0;
    ld_en = 1; ld_idx = 0; bus.data_in = 8'h55; tick();
    ld_en = 0;
    chk("shadow_b0", {56'h0, rd_a}, 64'h55);
    bank_swap = 1; tick();
    bank_swap = 0;
    chk("shadow_b1_clear", {56'h0, rd_a}, 64'h00);
    ld_en = 1; bus.data_in = 8'hAA; tick();
    ld_en = 0;
    chk("shadow_b1", {56'h0, rd_a}, 64'hAA);
    bank_swap = 1; tick();
    bank_swap = 0;
    chk("shadow_back", {56'h0, rd_a}, 64'h55);
`endif

    tick();
    chk("done_count", 64'(done_cnt), 64'd3);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_regfile_gen.md
Name: cpu_regfile_gen

Overview:
- Parametrised successor to the CPU register file: NREG general data registers, NPTR 2-byte pointer registers (PC/AD/BA class), and a status register with a protected-bit mask.
- Adds a serial spill sequencer that streams a pointer snapshot (hi, lo), then optionally status, onto the data bus under a ready handshake. This serves interrupt/JSR pushes without microcode stepping.
- Sits between the decoder/sequencer and the ALU/bus interface.

Parameters:
- DW, 8, data/register width; pointer width is 2*DW.
- NREG, 8, number of general registers (index width $clog2(NREG)).
- NPTR, 4, number of pointer registers (index width $clog2(NPTR)).
- STATUS_RST, 8'h20, status reset value.
- STATUS_KEEP, 8'h30, status bits never written by status_ld.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freezes all state, including the sequencer.
- data_in  in  DW  bus read data.
- alu_out  in  DW  ALU result.
- ld_en / ld_idx  in  1 / log2(NREG)  load data_in into register ld_idx.
- dest_en / dest_idx  in  1 / log2(NREG)  load alu_out into register dest_idx.
- rd_a_idx, rd_b_idx  in  log2(NREG)  read selects.
- rd_a, rd_b  out  DW  combinational read data.
- ptr_idx  in  log2(NPTR)  pointer target.
- ptr_op  in  3  NONE, LDL, LDH, ALUL, ALUH, INC, DEC, CLRH.
- ptr_q  out  NPTR*2*DW  all pointers, flat; pointer k at [k*2DW +: 2DW].
- status_we  in  DW  per-bit write enable for status_d.
- status_d  in  DW  next status bits.
- status_ld  in  1  load status from data_in (PLP).
- status_q  out  DW  status.
- st_en / st_idx  in  1 / log2(NREG)  drive register st_idx on the bus.
- spill_req  in  1  start spill.
- spill_ptr  in  log2(NPTR)  pointer to spill.
- spill_stat  in  1  append status byte.
- spill_brk  in  1  B-bit value for the status byte.
- bus_ready  in  1  bus accepted the current byte.
- data_out  out  DW  bus write data.
- data_oe  out  1  bus drive enable.
- spill_busy  out  1  sequencer active.
- spill_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (rst=0, asynchronous): registers 0, pointers 0, status=STATUS_RST, state IDLE, data_oe=0, spill_busy=0, spill_done=0, data_out=0.
- stall=1: no register, pointer, status or state change; spill_done forced 0; data_oe/data_out hold their current values.
- General register write priority: ld_en over dest_en when both target the same index. Different indices are both written in the same cycle. Writes land at the next edge; reads are combinational and show the pre-edge value.
- Pointer ops on ptr_idx:
  - LDL/LDH: low/high byte from data_in.
  - ALUL/ALUH: low/high byte from alu_out.
  - INC/DEC: full-width +/-1, modulo 2^(2DW); 16'hFFFF+1=0.
  - CLRH: high byte to 0.
- Status:
  - status_ld writes data_in on bits not in STATUS_KEEP; it has priority over status_we.
  - Otherwise bits with status_we=1 take status_d.
- Bus drive: data_oe=1 when spill_busy or st_en; the spill sequencer has priority over st_en.
- Sequencer FSM:
  - IDLE: spill_req && !stall → snapshot the pointer and, if spill_stat, status; go to HI. spill_req while busy is ignored.
  - HI: drive snap[2DW-1:DW]; on bus_ready → LO.
  - LO: drive snap[DW-1:0]; on bus_ready → ST if spill_stat was captured, else IDLE with spill_done.
  - ST: drive snapshot status with bit 4 = captured spill_brk, bit 5 = 1; on bus_ready → IDLE with spill_done.
- Snapshot isolation: pointer/status writes during a spill do not alter the bytes streamed.
- Latency: 2 or 3 accepted beats; minimum 3 or 4 cycles from request to spill_done.
- Reset mid-spill: return to IDLE, data_oe=0, no spill_done.

Optional Feature:
- CPU_REGFILE_SHADOW_EN defined: adds input bank_swap and a second general-register bank. A bank_swap pulse (not stalled) toggles the active bank in one cycle; all ld/dest/rd/st accesses go to the active bank. Pointers and status are not banked. Reset selects bank 0 and clears both banks.
- Undefined: single bank; no bank_swap port.

Decomposition:
- Package cpu_regfile_pkg: ptr_op_e enum, spill_state_e enum, status bit index constants (N=7, V=6, B=4, D=3, I=2, Z=1, C=0).
- Sub-module spill_seq holds the FSM and the snapshot registers.

Test Plan:
- Reset: rst=0 mid-operation → status_q=8'h20, ptr_q=0, data_oe=0; release, then ld_en idx3 with data_in=8'hA5 → rd_a(3)=8'hA5 next cycle.
- Priority: ld_en and dest_en both idx2, data_in=8'h11, alu_out=8'h22 → reg2=8'h11. With dest_idx=4 instead → reg2=8'h11 and reg4=8'h22.
- Pointer wrap: LDL 8'hFF, LDH 8'hFF, then INC → pointer=16'h0000; DEC → 16'hFFFF; CLRH → 16'h00FF.
- Spill: ptr1=16'hC012, status=8'hC3, spill_stat=1, spill_brk=0, bus_ready stuck low 2 cycles then high → bytes C0, 12, E3 in order; spill_done one pulse; INC on ptr1 during the spill does not change the streamed bytes.
- Status: status_ld with data_in=8'hFF from 8'h20 → 8'hEF; stall asserted during a spill HI beat with bus_ready=1 → no advance.
- Shadow (macro on): write reg0=8'h55, bank_swap, rd reg0=0, write 8'hAA, bank_swap → reg0=8'h55.
